// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse key sequencer:
//   - FSM state encoding (IDLE, LOAD, CAPTURE, MARK, SPACE, CGAP, WGAP)
//   - code/symbol widths and the supported code range
//   - find_below(): picks the next present symbol position below a limit
// ---------------------------------------------------------------------------
package morse_pkg;

    localparam int CODE_W = 6;
    localparam int SYM_W  = 5;

    localparam logic [CODE_W-1:0] NUM_MAX    = 6'd35;
    localparam logic [CODE_W-1:0] SPACE_CODE = 6'd36;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        MARK    = 3'd3,
        SPACE   = 3'd4,
        CGAP    = 3'd5,
        WGAP    = 3'd6
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } sym_sel_t;

    // Highest position strictly below 'limit' whose display bit is set.
    // Symbols play from the top position downwards, so this gives both the
    // first symbol (limit = SYM_W) and the one following position 'limit'.
    function automatic sym_sel_t find_below(input logic [SYM_W-1:0] disp,
                                            input int limit);
        sym_sel_t r;
        r = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (i < limit && disp[i]) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// ---------------------------------------------------------------------------
// morse_unit_timer
// Loadable down-counter. The sequencer loads it with (duration - 1) on entry
// to each timed state and leaves the state when zero is high.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   W  value to load
//   zero      out  count has reached zero
// ---------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/morse_key_sequencer.sv
// ---------------------------------------------------------------------------
// morse_key_sequencer
// Accepts one character code per handshake (0-9 digits, 10-35 = A-Z), asks
// the external codifMorse encoder for its 5-symbol pattern and plays that
// pattern out as a timed on/off key line.
//   dot = 1 unit, dash = DASH_UNITS, inter-symbol gap = 1 unit,
//   trailing gap = CHAR_GAP_UNITS, one unit = UNIT_CYCLES clocks.
// Optional feature macro: MORSE_WORD_GAP_EN -- code 36 becomes a word space
// (WORD_GAP_UNITS of silence); without it code 36 is reported as invalid.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   char_valid   in   char_num is valid
//   char_num     in   6  character code
//   char_ready   out  sequencer can accept a character (IDLE only)
//   enc_num      out  6  code presented to codifMorse.num
//   enc_ready    out  codifMorse.ready strobe (LOAD only)
//   enc_morse    in   5  codifMorse.morse: 1 = dash, 0 = dot
//   enc_display  in   5  codifMorse.display: 1 = symbol position present
//   key_out      out  key line, high while a dot or dash sounds
//   sym_dash     out  high while key_out is high for a dash
//   busy         out  character in progress
//   err_invalid  out  one-cycle pulse for an unsupported accepted code
// ---------------------------------------------------------------------------
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [CODE_W-1:0] char_num,
    output logic              char_ready,
    output logic [CODE_W-1:0] enc_num,
    output logic              enc_ready,
    input  logic [SYM_W-1:0]  enc_morse,
    input  logic [SYM_W-1:0]  enc_display,
    output logic              key_out,
    output logic              sym_dash,
    output logic              busy,
    output logic              err_invalid
);

    localparam int GAP_MAX  = (CHAR_GAP_UNITS > WORD_GAP_UNITS) ? CHAR_GAP_UNITS : WORD_GAP_UNITS;
    localparam int UNIT_MAX = (DASH_UNITS > GAP_MAX) ? DASH_UNITS : GAP_MAX;
    localparam int CNT_W    = $clog2(UNIT_CYCLES * UNIT_MAX + 1);

    // Timer load values are durations minus one: the state is left when the
    // counter reads zero.
    localparam logic [CNT_W-1:0] DOT_T   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_T  = CNT_W'(UNIT_CYCLES * DASH_UNITS - 1);
    localparam logic [CNT_W-1:0] SPACE_T = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CGAP_T  = CNT_W'(UNIT_CYCLES * CHAR_GAP_UNITS - 1);
    // An invalid code spends two cycles in CGAP so err_invalid can be a
    // registered pulse and char_ready returns two edges after the transfer.
    localparam logic [CNT_W-1:0] INV_T   = CNT_W'(1);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WGAP_T  = CNT_W'(UNIT_CYCLES * WORD_GAP_UNITS - 1);
`endif

    state_t              state;
    logic [SYM_W-1:0]    morse_q;
    logic [SYM_W-1:0]    disp_q;
    logic [2:0]          idx;
    logic                inv;
    logic                take;
    logic                code_ok;
    logic                tm_load;
    logic [CNT_W-1:0]    tm_val;
    logic                tm_zero;
    sym_sel_t            first;
    sym_sel_t            below;

    assign take    = char_valid && char_ready;
    assign code_ok = (char_num <= NUM_MAX);
    assign first   = find_below(enc_display, SYM_W);
    assign below   = find_below(disp_q, int'(idx));

    morse_unit_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tm_load),
        .load_val (tm_val),
        .zero     (tm_zero)
    );

    // Timer loads happen on the same edges where the FSM enters a timed
    // state, so the count is ready on the first cycle in that state.
    always_comb begin
        tm_load = 1'b0;
        tm_val  = '0;
        case (state)
            IDLE: begin
                if (take && !code_ok) begin
                    tm_load = 1'b1;
`ifdef MORSE_WORD_GAP_EN
                    tm_val  = (char_num == SPACE_CODE) ? WGAP_T : INV_T;
`else
                    tm_val  = INV_T;
`endif
                end
            end
            CAPTURE: begin
                tm_load = 1'b1;
                if (!first.found)
                    tm_val = CGAP_T;
                else if (enc_morse[first.idx])
                    tm_val = DASH_T;
                else
                    tm_val = DOT_T;
            end
            MARK: begin
                if (tm_zero) begin
                    tm_load = 1'b1;
                    tm_val  = below.found ? SPACE_T : CGAP_T;
                end
            end
            SPACE: begin
                if (tm_zero) begin
                    tm_load = 1'b1;
                    tm_val  = morse_q[idx] ? DASH_T : DOT_T;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer FSM. char_ready/busy/enc_ready are set on the edge that
    // enters their state; key_out, sym_dash and err_invalid are registered
    // from the current state, which puts the key rise three edges after the
    // transfer while keeping every mark and gap its exact length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            enc_num     <= '0;
            morse_q     <= '0;
            disp_q      <= '0;
            idx         <= '0;
            inv         <= 1'b0;
            char_ready  <= 1'b1;
            busy        <= 1'b0;
            enc_ready   <= 1'b0;
            key_out     <= 1'b0;
            sym_dash    <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            key_out     <= (state == MARK);
            sym_dash    <= (state == MARK) && morse_q[idx];
            err_invalid <= (state == CGAP) && inv && !tm_zero;
            enc_ready   <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        enc_num    <= char_num;
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                        if (code_ok) begin
                            state     <= LOAD;
                            enc_ready <= 1'b1;
                        end
`ifdef MORSE_WORD_GAP_EN
                        else if (char_num == SPACE_CODE) begin
                            state <= WGAP;
                        end
`endif
                        else begin
                            state <= CGAP;
                            inv   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    morse_q <= enc_morse;
                    disp_q  <= enc_display;
                    if (first.found) begin
                        idx   <= first.idx;
                        state <= MARK;
                    end else begin
                        state <= CGAP;
                    end
                end
                MARK: begin
                    if (tm_zero) begin
                        if (below.found) begin
                            idx   <= below.idx;
                            state <= SPACE;
                        end else begin
                            state <= CGAP;
                        end
                    end
                end
                SPACE: begin
                    if (tm_zero)
                        state <= MARK;
                end
                CGAP, WGAP: begin
                    if (tm_zero) begin
                        state      <= IDLE;
                        inv        <= 1'b0;
                        char_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_morse_key_sequencer
// Drives characters into morse_key_sequencer (UNIT_CYCLES=2) with a stand-in
// codifMorse that scatters each pattern over random display positions, and
// compares every output cycle by cycle against a waveform built from the
// Morse table and the timing rules.
// ---------------------------------------------------------------------------
module tb_morse_key_sequencer;

    localparam int U     = 2;
    localparam int DASHU = 3;
    localparam int CGAPU = 3;
    localparam int WGAPU = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       char_valid;
    logic [5:0] char_num;
    logic       char_ready;
    logic [5:0] enc_num;
    logic       enc_ready;
    logic [4:0] enc_morse;
    logic [4:0] enc_display;
    logic       key_out;
    logic       sym_dash;
    logic       busy;
    logic       err_invalid;

    int assertCount = 0;
    int failCount   = 0;

    string morseTab [36] = '{
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
        "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    always #5 clk = ~clk;

    morse_key_sequencer #(
        .UNIT_CYCLES    (U),
        .DASH_UNITS     (DASHU),
        .CHAR_GAP_UNITS (CGAPU),
        .WORD_GAP_UNITS (WGAPU)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_num    (char_num),
        .char_ready  (char_ready),
        .enc_num     (enc_num),
        .enc_ready   (enc_ready),
        .enc_morse   (enc_morse),
        .enc_display (enc_display),
        .key_out     (key_out),
        .sym_dash    (sym_dash),
        .busy        (busy),
        .err_invalid (err_invalid)
    );

    // Stand-in encoder: symbols keep their order but land on random display
    // positions, absent positions carry junk morse bits.
    function automatic logic [9:0] encodeScatter(input logic [5:0] code);
        string      s;
        logic [4:0] m;
        logic [4:0] d;
        int         r;
        int         j;
        m = 5'($urandom);
        d = '0;
        j = 0;
        if (code > 6'd35) return 10'd0;
        s = morseTab[code];
        r = s.len();
        for (int p = 4; p >= 0; p--) begin
            if (r > 0 && int'($urandom_range(p, 0)) < r) begin
                d[p] = 1'b1;
                m[p] = (s[j] == "-");
                j++;
                r--;
            end
        end
        return {m, d};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_morse   <= '0;
            enc_display <= '0;
        end else if (enc_ready) begin
            {enc_morse, enc_display} <= encodeScatter(enc_num);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Sends one character (char_valid/char_num already driven) and checks all
    // outputs each cycle until the sequencer is ready again. nextCode >= 0
    // keeps char_valid high with that code for a back-to-back transfer.
    task automatic applyStimulus(input int code, input int nextCode);
        logic keyQ [$];
        logic dashQ [$];
        bit   valid;
        bit   isWgap;
        int   lastK;
        int   waitCycles;
        string s;
        valid      = (code <= 35);
        waitCycles = 0;
`ifdef MORSE_WORD_GAP_EN
        isWgap = (code == 36);
`else
        isWgap = 1'b0;
`endif
        repeat (3) begin keyQ.push_back(1'b0); dashQ.push_back(1'b0); end
        if (valid) begin
            s = morseTab[code];
            for (int i = 0; i < s.len(); i++) begin
                bit d;
                d = (s[i] == "-");
                repeat (U * (d ? DASHU : 1)) begin keyQ.push_back(1'b1); dashQ.push_back(d); end
                if (i < s.len() - 1)
                    repeat (U) begin keyQ.push_back(1'b0); dashQ.push_back(1'b0); end
            end
            repeat (U * CGAPU) begin keyQ.push_back(1'b0); dashQ.push_back(1'b0); end
            lastK = keyQ.size() - 1;
        end else if (isWgap) begin
            lastK = U * WGAPU;
        end else begin
            lastK = 2;
        end

        while (char_ready !== 1'b1 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("ready_before_transfer", char_ready, 1);
        if (char_ready !== 1'b1) return;

        @(posedge clk);
        for (int k = 0; k <= lastK; k++) begin
            @(negedge clk);
            checkOutput("key_out", key_out, (k < keyQ.size()) ? keyQ[k] : 1'b0);
            checkOutput("sym_dash", sym_dash, (k < dashQ.size()) ? dashQ[k] : 1'b0);
            checkOutput("char_ready", char_ready, (k == lastK));
            checkOutput("busy", busy, (k != lastK));
            checkOutput("err_invalid", err_invalid, (!valid && !isWgap && k == 1));
            checkOutput("enc_ready", enc_ready, (valid && k == 0));
            if (k == 0) begin
                checkOutput("enc_num", enc_num, code[5:0]);
                if (nextCode >= 0) begin
                    char_num = nextCode[5:0];
                end else begin
                    char_valid = 1'b0;
                    char_num   = 6'($urandom);
                end
            end
        end
    endtask

    // Reset asserted during the third key-high cycle of the first dash of '0'.
    task automatic resetMidDash();
        char_valid = 1'b1;
        char_num   = 6'd0;
        @(posedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) char_valid = 1'b0;
        end
        checkOutput("dash_before_reset", sym_dash, 1);
        reset = 1'b0;
        #1;
        checkOutput("reset_key_out", key_out, 0);
        checkOutput("reset_sym_dash", sym_dash, 0);
        checkOutput("reset_char_ready", char_ready, 1);
        checkOutput("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_reset_key", key_out, 0);
            checkOutput("post_reset_ready", char_ready, 1);
            checkOutput("post_reset_busy", busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int codes [$];
        bit b2b [$];
        reset      = 1'b0;
        char_valid = 1'b0;
        char_num   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_char_ready", char_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_key_out", key_out, 0);
        checkOutput("rst_sym_dash", sym_dash, 0);
        checkOutput("rst_err", err_invalid, 0);
        checkOutput("rst_enc_ready", enc_ready, 0);
        checkOutput("rst_enc_num", enc_num, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed characters");
        char_valid = 1'b1; char_num = 6'd14; applyStimulus(14, -1);
        @(negedge clk);
        char_valid = 1'b1; char_num = 6'd10; applyStimulus(10, -1);
        @(negedge clk);
        char_valid = 1'b1; char_num = 6'd0;  applyStimulus(0, -1);
        @(negedge clk);
        char_valid = 1'b1; char_num = 6'd40; applyStimulus(40, -1);
        @(negedge clk);
        char_valid = 1'b1; char_num = 6'd29; applyStimulus(29, 14);
        applyStimulus(14, -1);
        @(negedge clk);
        char_valid = 1'b1; char_num = 6'd36; applyStimulus(36, -1);
        @(negedge clk);

        $display("[TB] reset during a dash");
        resetMidDash();

        $display("[TB] random characters");
        for (int i = 0; i < 40; i++) begin
            codes.push_back(($urandom_range(9, 0) < 8) ? int'($urandom_range(35, 0)) : int'($urandom_range(63, 36)));
            b2b.push_back(1'($urandom_range(1, 0)));
        end
        char_valid = 1'b1;
        char_num   = 6'(codes[0]);
        for (int i = 0; i < codes.size(); i++) begin
            if (b2b[i] && i + 1 < codes.size()) begin
                applyStimulus(codes[i], codes[i + 1]);
            end else begin
                applyStimulus(codes[i], -1);
                repeat ($urandom_range(3, 0)) begin
                    @(negedge clk);
                    checkOutput("idle_key", key_out, 0);
                    checkOutput("idle_ready", char_ready, 1);
                end
                if (i + 1 < codes.size()) begin
                    char_valid = 1'b1;
                    char_num   = 6'(codes[i + 1]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
